// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the selected hazard
// condition, and the register-match helper used by the hazard detector.
package hazard_controller_pkg;

  localparam int NB_OPERAND = 5;
  localparam int NB_WAIT    = 8;

  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_DMEM_WAIT = 2'd1,
    HZ_IMEM_WAIT = 2'd2,
    HZ_FAULT     = 2'd3
  } hazard_state_t;

  // Highest-priority condition active this cycle; drives both controls and FSM.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_FAULT,
    SEL_DMEM,
    SEL_LOAD_USE,
    SEL_BRANCH,
    SEL_IMEM
  } hazard_sel_t;

  function automatic logic reg_match(input logic [NB_OPERAND-1:0] rd,
                                     input logic [NB_OPERAND-1:0] rs,
                                     input logic                  use_rs);
    return use_rs && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller: hazard inputs
// from the pipeline registers and the per-stage enable/bubble/flush controls.
interface hazard_controller_if
  import hazard_controller_pkg::*;
#(
  parameter int NB_CNT       = 32,
  parameter int NB_FLUSH_CNT = 16
) ();

  logic [NB_OPERAND-1:0]   i_if_id_rs1;
  logic [NB_OPERAND-1:0]   i_if_id_rs2;
  logic                    i_if_id_use_rs1;
  logic                    i_if_id_use_rs2;
  logic                    i_if_id_is_branch;
  logic                    i_branch_taken;
  logic [NB_OPERAND-1:0]   i_id_ex_rd;
  logic                    i_id_ex_rf_write;
  logic                    i_id_ex_mem_read;
  logic [NB_OPERAND-1:0]   i_ex_mem_rd;
  logic                    i_ex_mem_mem_read;
  logic                    i_imem_ready;
  logic                    i_dmem_req;
  logic                    i_dmem_ready;

  logic                    o_pc_en;
  logic                    o_if_id_en;
  logic                    o_if_id_flush;
  logic                    o_id_ex_en;
  logic                    o_id_ex_bubble;
  logic                    o_ex_mem_en;
  logic                    o_mem_wb_bubble;
  hazard_state_t           o_state;
  logic                    o_fault;
  logic [NB_CNT-1:0]       o_stall_count;
  logic [NB_FLUSH_CNT-1:0] o_flush_count;

  modport master (
    output i_if_id_rs1, i_if_id_rs2, i_if_id_use_rs1, i_if_id_use_rs2,
           i_if_id_is_branch, i_branch_taken, i_id_ex_rd, i_id_ex_rf_write,
           i_id_ex_mem_read, i_ex_mem_rd, i_ex_mem_mem_read, i_imem_ready,
           i_dmem_req, i_dmem_ready,
    input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_bubble,
           o_ex_mem_en, o_mem_wb_bubble, o_state, o_fault, o_stall_count,
           o_flush_count
  );

  modport slave (
    input  i_if_id_rs1, i_if_id_rs2, i_if_id_use_rs1, i_if_id_use_rs2,
           i_if_id_is_branch, i_branch_taken, i_id_ex_rd, i_id_ex_rf_write,
           i_id_ex_mem_read, i_ex_mem_rd, i_ex_mem_mem_read, i_imem_ready,
           i_dmem_req, i_dmem_ready,
    output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_bubble,
           o_ex_mem_en, o_mem_wb_bubble, o_state, o_fault, o_stall_count,
           o_flush_count
  );

endinterface

// File: rtl/hazard_controller_detect.sv
// Combinational register-hazard detection: loads feeding the ID instruction from EX,
// and loads in MEM feeding a branch that resolves its operands in ID.
module hazard_detect
  import hazard_controller_pkg::*;
(
  input  logic [NB_OPERAND-1:0] rs1,
  input  logic [NB_OPERAND-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic                  is_branch,
  input  logic [NB_OPERAND-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic [NB_OPERAND-1:0] ex_mem_rd,
  input  logic                  ex_mem_mem_read,
  output logic                  load_use,
  output logic                  branch_load_use
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = reg_match(id_ex_rd, rs1, use_rs1) || reg_match(id_ex_rd, rs2, use_rs2);
  assign mem_match = reg_match(ex_mem_rd, rs1, use_rs1) || reg_match(ex_mem_rd, rs2, use_rs2);

  assign load_use        = id_ex_mem_read && ex_match;
  // A branch compares in ID, so even a load one stage further on is too late to forward.
  assign branch_load_use = is_branch && ex_mem_mem_read && mem_match;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: per-stage enable/bubble/flush from hazards, a
// memory-wait FSM with data-memory watchdog, and saturating stall/flush counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int NB_CNT       = 32,
  parameter int NB_FLUSH_CNT = 16,
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  hazard_controller_if.slave hz
);

  localparam logic [NB_WAIT-1:0] TIMEOUT_C = NB_WAIT'(DMEM_TIMEOUT);

  hazard_state_t           state;
  hazard_sel_t             sel;
  logic [NB_WAIT-1:0]      wait_cnt;
  logic [NB_CNT-1:0]       stall_cnt;
  logic [NB_FLUSH_CNT-1:0] flush_cnt;
  logic                    load_use;
  logic                    branch_load_use;
  logic                    dmem_stall;
  logic                    pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic                    ex_mem_en, mem_wb_bubble;
  logic                    unused_rf_write;

  function automatic logic [NB_CNT-1:0] sat_inc_stall(input logic [NB_CNT-1:0] c);
    return (c == '1) ? c : c + NB_CNT'(1);
  endfunction

  function automatic logic [NB_FLUSH_CNT-1:0] sat_inc_flush(input logic [NB_FLUSH_CNT-1:0] c);
    return (c == '1) ? c : c + NB_FLUSH_CNT'(1);
  endfunction

  hazard_detect u_detect (
    .rs1             (hz.i_if_id_rs1),
    .rs2             (hz.i_if_id_rs2),
    .use_rs1         (hz.i_if_id_use_rs1),
    .use_rs2         (hz.i_if_id_use_rs2),
    .is_branch       (hz.i_if_id_is_branch),
    .id_ex_rd        (hz.i_id_ex_rd),
    .id_ex_mem_read  (hz.i_id_ex_mem_read),
    .ex_mem_rd       (hz.i_ex_mem_rd),
    .ex_mem_mem_read (hz.i_ex_mem_mem_read),
    .load_use        (load_use),
    .branch_load_use (branch_load_use)
  );

  // ALU results are covered by forwarding, so only the load flag matters here.
  assign unused_rf_write = hz.i_id_ex_rf_write;
  assign dmem_stall      = hz.i_dmem_req && !hz.i_dmem_ready;

  always_comb begin
    sel = SEL_NONE;
    if (state == HZ_FAULT)                  sel = SEL_FAULT;
    else if (dmem_stall)                    sel = SEL_DMEM;
    else if (load_use || branch_load_use)   sel = SEL_LOAD_USE;
    else if (hz.i_branch_taken)             sel = SEL_BRANCH;
    else if (!hz.i_imem_ready)              sel = SEL_IMEM;
  end

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!i_rst) begin
      case (sel)
        SEL_FAULT: ;
        SEL_DMEM:  mem_wb_bubble = 1'b1;
        SEL_LOAD_USE: begin
          id_ex_en     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_en    = 1'b1;
        end
        SEL_BRANCH, SEL_IMEM: begin
          pc_en       = (sel == SEL_BRANCH);
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
        end
        default: begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= HZ_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && sel != SEL_FAULT) stall_cnt <= sat_inc_stall(stall_cnt);
      if (sel == SEL_BRANCH)          flush_cnt <= sat_inc_flush(flush_cnt);
      case (state)
        HZ_FAULT: begin
          state    <= HZ_FAULT;
          wait_cnt <= '0;
        end
        HZ_DMEM_WAIT: begin
          if (!dmem_stall) begin
            state    <= (sel == SEL_IMEM) ? HZ_IMEM_WAIT : HZ_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT_C) begin
            state    <= HZ_FAULT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          if (dmem_stall) begin
            state    <= HZ_DMEM_WAIT;
            wait_cnt <= 8'd1;
          end else begin
            state    <= (sel == SEL_IMEM) ? HZ_IMEM_WAIT : HZ_RUN;
            wait_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign hz.o_pc_en         = pc_en;
  assign hz.o_if_id_en      = if_id_en;
  assign hz.o_if_id_flush   = if_id_flush;
  assign hz.o_id_ex_en      = id_ex_en;
  assign hz.o_id_ex_bubble  = id_ex_bubble;
  assign hz.o_ex_mem_en     = ex_mem_en;
  assign hz.o_mem_wb_bubble = mem_wb_bubble;
  assign hz.o_state         = state;
  assign hz.o_fault         = (state == HZ_FAULT);
  assign hz.o_stall_count   = stall_cnt;
  assign hz.o_flush_count   = flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a control-output vector table plus
// hand-written multi-cycle sequences for waits, watchdog, counters and reset.
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  localparam logic [6:0] CN = 7'b1101010;  // normal
  localparam logic [6:0] CS = 7'b0001110;  // load-use stall
  localparam logic [6:0] CB = 7'b1111010;  // branch redirect
  localparam logic [6:0] CI = 7'b0111010;  // imem stall
  localparam logic [6:0] CD = 7'b0000001;  // dmem stall
  localparam logic [6:0] CZ = 7'b0000000;  // frozen / reset

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       use1, use2, is_br, taken;
    logic [4:0] ex_rd;
    logic       ex_load, ex_wr;
    logic [4:0] mem_rd;
    logic       mem_load, imem_rdy, dreq, drdy;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[13];
  vec_t idle;

  hazard_controller_if #(.NB_CNT(32), .NB_FLUSH_CNT(2)) hz ();

  hazard_controller #(.NB_CNT(32), .NB_FLUSH_CNT(2), .DMEM_TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic use1, input logic use2,
                              input logic is_br, input logic taken,
                              input logic [4:0] ex_rd, input logic ex_load,
                              input logic ex_wr, input logic [4:0] mem_rd,
                              input logic mem_load, input logic imem_rdy,
                              input logic dreq, input logic drdy,
                              input logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
    v.is_br = is_br; v.taken = taken; v.ex_rd = ex_rd; v.ex_load = ex_load;
    v.ex_wr = ex_wr; v.mem_rd = mem_rd; v.mem_load = mem_load;
    v.imem_rdy = imem_rdy; v.dreq = dreq; v.drdy = drdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hz.i_if_id_rs1       = v.rs1;
    hz.i_if_id_rs2       = v.rs2;
    hz.i_if_id_use_rs1   = v.use1;
    hz.i_if_id_use_rs2   = v.use2;
    hz.i_if_id_is_branch = v.is_br;
    hz.i_branch_taken    = v.taken;
    hz.i_id_ex_rd        = v.ex_rd;
    hz.i_id_ex_mem_read  = v.ex_load;
    hz.i_id_ex_rf_write  = v.ex_wr;
    hz.i_ex_mem_rd       = v.mem_rd;
    hz.i_ex_mem_mem_read = v.mem_load;
    hz.i_imem_ready      = v.imem_rdy;
    hz.i_dmem_req        = v.dreq;
    hz.i_dmem_ready      = v.drdy;
  endtask

  function automatic logic [6:0] ctl();
    return {hz.o_pc_en, hz.o_if_id_en, hz.o_if_id_flush, hz.o_id_ex_en,
            hz.o_id_ex_bubble, hz.o_ex_mem_en, hz.o_mem_wb_bubble};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_state", 32'(hz.o_state), 32'(HZ_RUN));
    @(negedge clk);
    apply(idle);
    rst = 1'b0;
  endtask

  initial begin
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, CN);
    tbl[0]  = idle;
    tbl[1]  = mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, CS);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, CN);
    tbl[3]  = mk(3, 9, 1, 0, 0, 0, 9, 1, 1, 0, 0, 1, 0, 0, CN);
    tbl[4]  = mk(3, 9, 1, 1, 0, 0, 9, 1, 1, 0, 0, 1, 0, 0, CS);
    tbl[5]  = mk(1, 7, 1, 1, 1, 1, 0, 0, 0, 7, 1, 1, 0, 0, CS);
    tbl[6]  = mk(1, 7, 1, 1, 0, 1, 0, 0, 0, 7, 1, 1, 0, 0, CB);
    tbl[7]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, CB);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CI);
    tbl[9]  = mk(5, 0, 1, 0, 1, 1, 5, 1, 1, 0, 0, 0, 1, 0, CD);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, CN);
    tbl[11] = mk(4, 0, 1, 0, 0, 0, 4, 0, 1, 0, 0, 1, 0, 0, CN);
    tbl[12] = mk(2, 2, 1, 1, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, CS);

    // reset values
    apply(tbl[1]);
    #2;
    chk("reset_ctl", 32'(ctl()), 32'(CZ));
    chk("reset_state", 32'(hz.o_state), 32'(HZ_RUN));
    chk("reset_fault", 32'(hz.o_fault), 0);
    chk("reset_stall", hz.o_stall_count, 0);
    chk("reset_flush", 32'(hz.o_flush_count), 0);
    @(negedge clk);
    apply(idle);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1 chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(tbl[i].exp));
    end

    // load-use: one stall cycle, counter 0 -> 1
    do_reset();
    apply(tbl[1]);
    #1 chk("lu_ctl", 32'(ctl()), 32'(CS));
    chk("lu_cnt0", hz.o_stall_count, 0);
    @(negedge clk);
    apply(idle);
    #1 chk("lu_cnt1", hz.o_stall_count, 1);
    chk("lu_after_ctl", 32'(ctl()), 32'(CN));
    @(negedge clk);
    #1 chk("lu_cnt_hold", hz.o_stall_count, 1);

    // load then dependent branch: two stalls, taken ignored while stalled
    do_reset();
    apply(mk(1, 7, 1, 1, 1, 1, 7, 1, 1, 0, 0, 1, 0, 0, CS));
    #1 chk("blu1_ctl", 32'(ctl()), 32'(CS));
    @(negedge clk);
    apply(mk(1, 7, 1, 1, 1, 1, 0, 0, 0, 7, 1, 1, 0, 0, CS));
    #1 chk("blu2_ctl", 32'(ctl()), 32'(CS));
    @(negedge clk);
    #1 chk("blu_flush0", 32'(hz.o_flush_count), 0);
    chk("blu_stall2", hz.o_stall_count, 2);
    apply(mk(1, 7, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, CB));
    #1 chk("blu_redirect", 32'(ctl()), 32'(CB));
    @(negedge clk);
    apply(idle);
    #1 chk("blu_flush1", 32'(hz.o_flush_count), 1);

    // three-cycle data-memory wait
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, CD));
      #1 chk($sformatf("dw%0d_ctl", k), 32'(ctl()), 32'(CD));
      @(negedge clk);
      #1 chk($sformatf("dw%0d_state", k), 32'(hz.o_state), 32'(HZ_DMEM_WAIT));
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, CN));
    #1 chk("dw_done_ctl", 32'(ctl()), 32'(CN));
    @(negedge clk);
    apply(idle);
    #1 chk("dw_run", 32'(hz.o_state), 32'(HZ_RUN));
    chk("dw_stall3", hz.o_stall_count, 3);
    chk("dw_noflush", 32'(hz.o_flush_count), 0);

    // watchdog: fault visible on the 6th cycle with timeout 4
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, CD));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("wd_state%0d", k), 32'(hz.o_state),
             (k < 5) ? 32'(HZ_DMEM_WAIT) : 32'(HZ_FAULT));
    end
    chk("wd_fault", 32'(hz.o_fault), 1);
    chk("wd_frozen", 32'(ctl()), 32'(CZ));
    chk("wd_stall5", hz.o_stall_count, 5);
    @(negedge clk);
    #1 chk("wd_stall_hold", hz.o_stall_count, 5);
    chk("wd_absorb", 32'(hz.o_state), 32'(HZ_FAULT));
    #2 rst = 1'b1;
    #1 chk("wd_rst_state", 32'(hz.o_state), 32'(HZ_RUN));
    chk("wd_rst_fault", 32'(hz.o_fault), 0);
    chk("wd_rst_stall", hz.o_stall_count, 0);
    chk("wd_rst_ctl", 32'(ctl()), 32'(CZ));
    @(negedge clk);
    apply(idle);
    rst = 1'b0;

    // ready on the timeout cycle: no fault
    @(negedge clk);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, CD));
    repeat (4) @(negedge clk);
    #1 chk("wdr_state4", 32'(hz.o_state), 32'(HZ_DMEM_WAIT));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, CN));
    @(negedge clk);
    apply(idle);
    #1 chk("wdr_run", 32'(hz.o_state), 32'(HZ_RUN));
    chk("wdr_nofault", 32'(hz.o_fault), 0);
    chk("wdr_stall4", hz.o_stall_count, 4);

    // imem stall vs redirect, then flush counter saturation
    do_reset();
    apply(tbl[7]);
    #1 chk("im_br_ctl", 32'(ctl()), 32'(CB));
    @(negedge clk);
    apply(tbl[8]);
    #1 chk("im_flush1", 32'(hz.o_flush_count), 1);
    chk("im_br_state", 32'(hz.o_state), 32'(HZ_RUN));
    chk("im_ctl", 32'(ctl()), 32'(CI));
    @(negedge clk);
    apply(idle);
    #1 chk("im_state", 32'(hz.o_state), 32'(HZ_IMEM_WAIT));
    @(negedge clk);
    #1 chk("im_back_run", 32'(hz.o_state), 32'(HZ_RUN));
    chk("im_stall1", hz.o_stall_count, 1);
    apply(tbl[6]);
    repeat (2) @(negedge clk);
    #1 chk("fl_cnt3", 32'(hz.o_flush_count), 3);
    @(negedge clk);
    #1 chk("fl_sat", 32'(hz.o_flush_count), 3);
    apply(idle);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
